// File: rtl/count_pwm_gen_if.sv
// Bus between the free-running counter side and the PWM generator.
// The bench or upstream logic drives it through master; the PWM block attaches through slave.
interface count_pwm_gen_if #(
    parameter int WIDTH  = 8,
    parameter int MISS_W = 4
);
    logic [WIDTH-1:0]  i_count;
    logic              i_enable;
    logic              i_duty_wr;
    logic [WIDTH-1:0]  i_duty_in;
    logic              i_irq_clr;
    logic              o_pwm_out;
    logic              o_wrap_pulse;
    logic              o_irq;
    logic [WIDTH-1:0]  o_duty_active;
    logic [MISS_W-1:0] o_miss_cnt;
    logic              o_busy;

    modport master (
        output i_count, i_enable, i_duty_wr, i_duty_in, i_irq_clr,
        input  o_pwm_out, o_wrap_pulse, o_irq, o_duty_active, o_miss_cnt, o_busy
    );

    modport slave (
        input  i_count, i_enable, i_duty_wr, i_duty_in, i_irq_clr,
        output o_pwm_out, o_wrap_pulse, o_irq, o_duty_active, o_miss_cnt, o_busy
    );
endinterface

// File: rtl/count_pwm_gen.sv
// PWM generator driven by an external free-running counter. Duty changes take effect only
// at period boundaries, and a period-end interrupt with missed-interrupt counting is provided.
module count_pwm_gen #(
    parameter int WIDTH  = 8,
    parameter int MISS_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    count_pwm_gen_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_count_q;
    logic [WIDTH-1:0]  r_duty_pend;
    logic              r_pend_flag;
    logic [WIDTH-1:0]  r_duty_active;
    logic              r_pwm;
    logic              r_wrap;
    logic              r_irq;
    logic [MISS_W-1:0] r_miss;

    logic              w_wrap;
    logic              w_apply;
    logic [WIDTH-1:0]  w_duty_next;
    logic              w_cmp;
    logic              w_pwm_next;
    logic              w_irq_set;

    // Any backwards step of the count, real wrap or counter restart, marks a period boundary.
    assign w_wrap      = (bus.i_count < r_count_q);
    assign w_apply     = w_wrap & r_pend_flag;
    assign w_duty_next = w_apply ? r_duty_pend : r_duty_active;
    assign w_cmp       = (bus.i_count < w_duty_next);
    assign w_irq_set   = w_wrap & ((r_state == S_RUN) | (r_state == S_DRAIN));

    always_comb begin
        w_state_next = r_state;
        w_pwm_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_enable) begin
                    w_state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!bus.i_enable) begin
                    w_state_next = S_IDLE;
                end else if (w_wrap) begin
                    w_state_next = S_RUN;
                    w_pwm_next   = w_cmp;
                end
            end
            S_RUN: begin
                w_pwm_next = w_cmp;
                if (!bus.i_enable) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Finishing the period takes priority over a renewed enable.
                if (w_wrap) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_pwm_next = w_cmp;
                    if (bus.i_enable) begin
                        w_state_next = S_RUN;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_count_q <= '0;
            r_pwm     <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count_q <= bus.i_count;
            r_pwm     <= w_pwm_next;
            r_wrap    <= w_wrap;
        end
    end

    // A write on the boundary cycle lands in the pending slot and waits for the next wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_duty_pend   <= '0;
            r_pend_flag   <= 1'b0;
            r_duty_active <= '0;
        end else begin
            if (w_apply) begin
                r_duty_active <= r_duty_pend;
            end
            if (bus.i_duty_wr) begin
                r_duty_pend <= bus.i_duty_in;
                r_pend_flag <= 1'b1;
            end else if (w_apply) begin
                r_pend_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq  <= 1'b0;
            r_miss <= '0;
        end else begin
            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if (bus.i_irq_clr) begin
                r_irq <= 1'b0;
            end
            if (bus.i_irq_clr) begin
                r_miss <= '0;
            end else if (w_irq_set && r_irq && (r_miss != {MISS_W{1'b1}})) begin
                r_miss <= r_miss + 1'b1;
            end
        end
    end

    assign bus.o_pwm_out     = r_pwm;
    assign bus.o_wrap_pulse  = r_wrap;
    assign bus.o_irq         = r_irq;
    assign bus.o_duty_active = r_duty_active;
    assign bus.o_miss_cnt    = r_miss;
    assign bus.o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_count_pwm_gen.sv
// Randomised scoreboard bench for count_pwm_gen: a behavioural model predicts each cycle's
// outputs into a queue, and a monitor compares them one cycle later.
module tb_count_pwm_gen;
    localparam int W = 8;
    localparam int M = 4;

    localparam int MODE_IDLE  = 0;
    localparam int MODE_ARMED = 1;
    localparam int MODE_RUN   = 2;
    localparam int MODE_DRAIN = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    count_pwm_gen_if #(.WIDTH(W), .MISS_W(M)) bus ();

    count_pwm_gen #(.WIDTH(W), .MISS_W(M)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic         pwm;
        logic         wrap;
        logic         irq;
        logic [W-1:0] dact;
        logic [M-1:0] miss;
        logic         busy;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   periods     = 0;
    bit   mon_on      = 0;

    // stimulus state
    logic [W-1:0] cnt    = '0;
    logic         g_en   = 1'b0;
    logic         g_rstn = 1'b0;
    bit           jump_en = 0;

    // reference model state
    int m_prev_count = 0;
    int m_pend_val   = 0;
    bit m_pending    = 0;
    int m_duty       = 0;
    bit m_irq        = 0;
    int m_miss       = 0;
    int m_mode       = MODE_IDLE;

    function automatic obs_t sample();
        obs_t o;
        o.pwm  = bus.o_pwm_out;
        o.wrap = bus.o_wrap_pulse;
        o.irq  = bus.o_irq;
        o.dact = bus.o_duty_active;
        o.miss = bus.o_miss_cnt;
        o.busy = bus.o_busy;
        return o;
    endfunction

    task automatic model_step(input bit rstn, input int c, input bit en, input bit wr,
                              input int din, input bit clr);
        obs_t e;
        bit   boundary;
        bit   in_window;
        bit   out_hi;
        int   duty_for_cycle;
        int   old_mode;
        if (!rstn) begin
            m_prev_count = 0; m_pend_val = 0; m_pending = 0; m_duty = 0;
            m_irq = 0; m_miss = 0; m_mode = MODE_IDLE;
            exp_q.push_back('0);
            return;
        end
        boundary       = (c < m_prev_count);
        duty_for_cycle = (boundary && m_pending) ? m_pend_val : m_duty;
        in_window      = (c < duty_for_cycle);
        old_mode       = m_mode;
        out_hi         = 0;
        if (old_mode == MODE_IDLE) begin
            if (en) m_mode = MODE_ARMED;
        end else if (old_mode == MODE_ARMED) begin
            if (!en) m_mode = MODE_IDLE;
            else if (boundary) begin m_mode = MODE_RUN; out_hi = in_window; end
        end else if (old_mode == MODE_RUN) begin
            out_hi = in_window;
            if (!en) m_mode = MODE_DRAIN;
        end else begin
            if (boundary) m_mode = MODE_IDLE;
            else begin out_hi = in_window; if (en) m_mode = MODE_RUN; end
        end
        if (boundary && (old_mode == MODE_RUN || old_mode == MODE_DRAIN)) begin
            if (m_irq && !clr) m_miss = (m_miss >= 15) ? 15 : m_miss + 1;
            m_irq = 1;
        end else if (clr) begin
            m_irq = 0;
        end
        if (clr) m_miss = 0;
        if (boundary && m_pending) begin
            m_duty    = m_pend_val;
            m_pending = 0;
        end
        if (wr) begin
            m_pend_val = din;
            m_pending  = 1;
        end
        m_prev_count = c;
        e.pwm  = out_hi;
        e.wrap = boundary;
        e.irq  = m_irq;
        e.dact = W'(m_duty);
        e.miss = M'(m_miss);
        e.busy = (m_mode != MODE_IDLE);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic en, input logic wr, input logic [W-1:0] din, input logic clr);
        @(negedge clk);
        if (jump_en && ($urandom_range(1499) == 0)) cnt = W'($urandom);
        else cnt = cnt + 1'b1;
        rst_n         = g_rstn;
        bus.i_count   = cnt;
        bus.i_enable  = en;
        bus.i_duty_wr = wr;
        bus.i_duty_in = din;
        bus.i_irq_clr = clr;
        model_step(g_rstn, int'(cnt), en, wr, int'(din), clr);
        mon_on = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(g_en, 1'b0, '0, 1'b0);
    endtask

    task automatic run_to(input logic [W-1:0] target);
        while (cnt + 1'b1 != target) cyc(g_en, 1'b0, '0, 1'b0);
    endtask

    task automatic random_cycles(input int n);
        logic [W-1:0] d;
        int           r;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(499) == 0) g_en = ~g_en;
            r = int'($urandom_range(9));
            d = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : W'($urandom);
            cyc(g_en, ($urandom_range(199) == 0), d, ($urandom_range(299) == 0));
        end
    endtask

    // monitor: one expected vector per clock once stimulus has started
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                vectors++;
                a = sample();
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_underflow: no expected vector, actual %h", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        miscompares++;
                        $display("FAIL outputs @%0t: actual pwm=%b wrap=%b irq=%b duty=%0d miss=%0d busy=%b, required pwm=%b wrap=%b irq=%b duty=%0d miss=%0d busy=%b",
                                 $time, a.pwm, a.wrap, a.irq, a.dact, a.miss, a.busy,
                                 e.pwm, e.wrap, e.irq, e.dact, e.miss, e.busy);
                    end
                end
                if (a.wrap) begin
                    periods++;
                    $display("period %0d @%0t: duty_active=%0d irq=%b miss_cnt=%0d busy=%b",
                             periods, $time, a.dact, a.irq, a.miss, a.busy);
                end
            end
        end
    end

    initial begin
        obs_t a;
        bus.i_count = '0; bus.i_enable = 1'b0; bus.i_duty_wr = 1'b0;
        bus.i_duty_in = '0; bus.i_irq_clr = 1'b0;

        // reset held while every input toggles
        g_rstn = 1'b0;
        for (int i = 0; i < 8; i++)
            cyc(1'($urandom), 1'($urandom), W'($urandom), 1'($urandom));

        // released but disabled: output stays low whatever else happens
        g_rstn = 1'b1; g_en = 1'b0;
        for (int i = 0; i < 300; i++)
            cyc(1'b0, ($urandom_range(49) == 0), W'($urandom), ($urandom_range(49) == 0));

        // duty 64 steady run
        cyc(g_en, 1'b1, 8'd64, 1'b0);
        g_en = 1'b1;
        idle(4 * 256);

        // mid-period write, then a write on the wrap cycle itself
        run_to(8'd100); cyc(g_en, 1'b1, 8'd200, 1'b0);
        run_to(8'd0);   cyc(g_en, 1'b1, 8'd30, 1'b0);
        idle(3 * 256);

        // duty extremes
        cyc(g_en, 1'b1, 8'd0, 1'b0);   idle(2 * 256 + 40);
        cyc(g_en, 1'b1, 8'd255, 1'b0); idle(3 * 256);

        // interrupt left pending long enough to saturate, then cleared on a wrap
        idle(20 * 256);
        run_to(8'd0); cyc(g_en, 1'b0, '0, 1'b1);
        idle(300);

        // random traffic including counter discontinuities
        jump_en = 1;
        random_cycles(8000);
        jump_en = 0;

        // disable mid-period: drain to the boundary
        g_en = 1'b1;
        cyc(g_en, 1'b1, 8'd90, 1'b0);
        idle(600);
        run_to(8'd30); g_en = 1'b0;
        idle(300);

        // asynchronous reset between clock edges
        g_en = 1'b1;
        cyc(g_en, 1'b1, 8'd128, 1'b0);
        idle(700);
        run_to(8'd77);
        @(posedge clk);
        #3;
        rst_n = 1'b0; g_rstn = 1'b0;
        #1;
        vectors++;
        a = sample();
        if (a !== obs_t'('0)) begin
            miscompares++;
            $display("FAIL async_reset: actual %h, required 0", a);
        end
        idle(3);
        g_rstn = 1'b1;
        random_cycles(600);

        @(posedge clk);
        #2;
        mon_on = 0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: actual %0d leftover, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
